// File: rtl/pucch_pkg.sv
// Shared types and constants for the PUCCH format 0/1 cyclic-shift datapath.
package pucch_pkg;

  localparam int unsigned POINT_SZ = 16;
  localparam int unsigned ANGLE_SZ = 34;
  localparam int unsigned NSC_PRB  = 12;

  typedef logic signed [POINT_SZ-1:0] sfix16_en15_t;
  typedef logic signed [ANGLE_SZ-1:0] sfix34_en30_t;

  // round(pi/6 * 2^30)
  localparam sfix34_en30_t PI6_SFIX34_EN30 = 34'sd562209904;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StLoad  = 2'd1;
  localparam state_t StIssue = 2'd2;
  localparam state_t StWait  = 2'd3;

  // -(-1.0) has no representation; clamp to the largest positive value.
  function automatic sfix16_en15_t sat_neg(input sfix16_en15_t x);
    if (x == 16'sh8000) return 16'sh7fff;
    return -x;
  endfunction

endpackage

// File: rtl/quad_prerot.sv
// Exact rotation of a complex sample by q quarter turns using swap/negate.
module quad_prerot
  import pucch_pkg::*;
(
  input  sfix16_en15_t re,
  input  sfix16_en15_t im,
  input  logic [1:0]   q,
  output sfix16_en15_t rot_re,
  output sfix16_en15_t rot_im
);

  always_comb begin
    rot_re = re;
    rot_im = im;
    unique case (q)
      2'd0: begin rot_re = re;          rot_im = im;          end
      2'd1: begin rot_re = sat_neg(im); rot_im = re;          end
      2'd2: begin rot_re = sat_neg(re); rot_im = sat_neg(im); end
      2'd3: begin rot_re = im;          rot_im = sat_neg(re); end
    endcase
  end

endmodule

// File: rtl/cs_phase_prerot.sv
// Cyclic-shift phase pre-rotation: quarter turns applied exactly, the residual
// +/-pi/6 handed to the CORDIC rotator one sample at a time.
module cs_phase_prerot
  import pucch_pkg::*;
#(
  parameter int unsigned NSC = NSC_PRB
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [3:0]          i_cs,
  input  logic [POINT_SZ-1:0] s_re,
  input  logic [POINT_SZ-1:0] s_im,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                i_rot_done,
  output logic [POINT_SZ-1:0] o_re,
  output logic [POINT_SZ-1:0] o_im,
  output logic [ANGLE_SZ-1:0] o_angle,
  output logic                o_en,
  output logic [3:0]          o_sc_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  state_t       state_q;
  logic [3:0]   n_q, k_q, cs_q, idx_q;
  logic         first_q, done_q, err_q;
  sfix16_en15_t re_q, im_q, rot_re, rot_im;
  sfix34_en30_t angle_q, res_angle;
  logic [1:0]   q_sel;
  logic [4:0]   k_sum;
  logic [3:0]   k_next;

  // k in 0..11 -> nearest quarter turn plus residual of -1, 0 or +1 twelfths.
  always_comb begin
    q_sel     = 2'd0;
    res_angle = '0;
    case (k_q)
      4'd1:  begin q_sel = 2'd0; res_angle = PI6_SFIX34_EN30;  end
      4'd2:  begin q_sel = 2'd1; res_angle = -PI6_SFIX34_EN30; end
      4'd3:  begin q_sel = 2'd1;                               end
      4'd4:  begin q_sel = 2'd1; res_angle = PI6_SFIX34_EN30;  end
      4'd5:  begin q_sel = 2'd2; res_angle = -PI6_SFIX34_EN30; end
      4'd6:  begin q_sel = 2'd2;                               end
      4'd7:  begin q_sel = 2'd2; res_angle = PI6_SFIX34_EN30;  end
      4'd8:  begin q_sel = 2'd3; res_angle = -PI6_SFIX34_EN30; end
      4'd9:  begin q_sel = 2'd3;                               end
      4'd10: begin q_sel = 2'd3; res_angle = PI6_SFIX34_EN30;  end
      4'd11: begin q_sel = 2'd0; res_angle = -PI6_SFIX34_EN30; end
      default: ;
    endcase
  end

  assign k_sum  = {1'b0, k_q} + {1'b0, cs_q};
  assign k_next = (k_sum >= 5'd12) ? 4'(k_sum - 5'd12) : k_sum[3:0];

  quad_prerot u_quad (
    .re     (s_re),
    .im     (s_im),
    .q      (q_sel),
    .rot_re (rot_re),
    .rot_im (rot_im)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      k_q     <= '0;
      cs_q    <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      angle_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start) begin
            if (i_cs <= 4'd11) begin
              cs_q    <= i_cs;
              n_q     <= '0;
              k_q     <= '0;
              state_q <= StLoad;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (s_valid) begin
            re_q    <= rot_re;
            im_q    <= rot_im;
            angle_q <= res_angle;
            idx_q   <= n_q;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          first_q <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          // The rotator's done from the previous sample may still be high here.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (i_rot_done) begin
            if (n_q == 4'(NSC - 1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              n_q     <= n_q + 4'd1;
              k_q     <= k_next;
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready  = (state_q == StLoad);
  assign o_en     = (state_q == StIssue);
  assign o_busy   = (state_q != StIdle);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_re     = re_q;
  assign o_im     = im_q;
  assign o_angle  = angle_q;
  assign o_sc_idx = idx_q;

endmodule

// File: tb/tb_cs_phase_prerot.sv
// Scoreboard bench for cs_phase_prerot with a simple rotator done model.
module tb_cs_phase_prerot;

  localparam logic signed [33:0] PI6 = 34'sd562209904;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [3:0]  i_cs = '0;
  logic [15:0] s_re = '0, s_im = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        i_rot_done = 1'b0;
  logic [15:0] o_re, o_im;
  logic [33:0] o_angle;
  logic        o_en;
  logic [3:0]  o_sc_idx;
  logic        o_busy, o_done, o_err;

  cs_phase_prerot dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_cs       (i_cs),
    .s_re       (s_re),
    .s_im       (s_im),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .i_rot_done (i_rot_done),
    .o_re       (o_re),
    .o_im       (o_im),
    .o_angle    (o_angle),
    .o_en       (o_en),
    .o_sc_idx   (o_sc_idx),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [33:0] ang;
    logic [3:0]         idx;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, en_cnt = 0;
  int cyc = 0, last_en = -100;
  int sidx = 0;
  bit stale = 0, stall = 0;
  logic signed [15:0] tab_re[12], tab_im[12];

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic logic signed [15:0] neg16(input logic signed [15:0] x);
    logic signed [16:0] w;
    w = -$signed({x[15], x});
    if (w > 17'sd32767) return 16'sd32767;
    return w[15:0];
  endfunction

  // Nearest quarter turn to 2*pi*k/12 and the leftover twelfth.
  function automatic exp_t make_exp(input int k, input logic signed [15:0] re,
                                    input logic signed [15:0] im, input int n);
    exp_t e;
    int q, r;
    q = ((k + 1) / 3) % 4;
    r = k - 3 * ((k + 1) / 3);
    e.ang = (r == 1) ? PI6 : (r == -1) ? -PI6 : 34'sd0;
    case (q)
      0: begin e.re = re;        e.im = im;        end
      1: begin e.re = neg16(im); e.im = re;        end
      2: begin e.re = neg16(re); e.im = neg16(im); end
      default: begin e.re = im;  e.im = neg16(re); end
    endcase
    e.idx = 4'(n);
    return e;
  endfunction

  // Sample source: the value presented at a negedge is taken at the next posedge.
  initial forever begin
    @(negedge clk);
    s_re    = tab_re[sidx % 12];
    s_im    = tab_im[sidx % 12];
    s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (s_valid && s_ready) sidx++;
  end

  // Rotator model: done level rises three cycles after each launch.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (stale) i_rot_done = 1'b1;
      else if (o_en) begin
        i_rot_done = 1'b0;
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_rot_done = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on every launch strobe.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_en) begin
      en_cnt++;
      chk("en_spacing_ge4", (cyc - last_en) >= 4, 1);
      last_en = cyc;
      if (sb.size() == 0) chk("unexpected_en", 1, 0);
      else begin
        e = sb.pop_front();
        chk($sformatf("re n=%0d", e.idx), $signed(o_re), e.re);
        chk($sformatf("im n=%0d", e.idx), $signed(o_im), e.im);
        chk($sformatf("angle n=%0d", e.idx), $signed(o_angle), e.ang);
        chk("sc_idx", o_sc_idx, e.idx);
      end
    end
  end

  task automatic load_tab(input int mode);
    for (int n = 0; n < 12; n++) begin
      case (mode)
        0: begin tab_re[n] = 16'sd16384;  tab_im[n] = 16'sd0;      end
        1: begin tab_re[n] = 16'(1000 * (n + 1)); tab_im[n] = 16'(3 - 500 * (n + 1)); end
        default: begin tab_re[n] = -16'sd32768; tab_im[n] = -16'sd32768; end
      endcase
    end
  endtask

  task automatic start_run(input int cs);
    sidx = 0;
    last_en = -100;
    en_cnt = 0;
    for (int n = 0; n < 12; n++) sb.push_back(make_exp((n * cs) % 12, tab_re[n], tab_im[n], n));
    i_start = 1'b1;
    i_cs = 4'(cs);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run(input int cs, input int inj_cs);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_run(cs);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      if (inj_cs >= 0 && c == 30) begin i_start = 1'b1; i_cs = 4'(inj_cs); end
      else i_start = 1'b0;
      @(negedge clk);
    end
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("done_pulses cs=%0d", cs), done_cnt - d0, 1);
    chk($sformatf("en_pulses cs=%0d", cs), en_cnt, 12);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_after_done", o_busy, 0);
    if (inj_cs >= 0) chk("midrun_start_no_err", err_cnt - e0, 0);
    sb.delete();
  endtask

  initial begin
    int d0, e0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_re", o_re, 0);
    chk("rst_angle", o_angle, 0);
    chk("rst_en_done_err", {o_en, o_done, o_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_tab(0); run(1, -1);
    stall = 1; load_tab(1); run(5, -1); stall = 0;
    load_tab(2); run(1, -1);

    // Illegal cyclic shift is rejected in IDLE.
    e0 = err_cnt;
    i_start = 1'b1; i_cs = 4'd12;
    @(negedge clk);
    i_start = 1'b0;
    chk("err_pulse", o_err, 1);
    chk("err_busy", o_busy, 0);
    chk("err_ready", s_ready, 0);
    @(negedge clk);
    chk("err_one_cycle", o_err, 0);
    repeat (3) @(negedge clk);
    chk("err_count", err_cnt - e0, 1);

    load_tab(1); run(7, 12);
    load_tab(1); run(4, 3);
    stale = 1; load_tab(1); run(11, -1); stale = 0;
    load_tab(1); run(0, -1);

    // Reset during the WAIT of sample 7.
    load_tab(0);
    d0 = done_cnt;
    start_run(1);
    for (int c = 0; c < 2000 && !(o_en && o_sc_idx == 4'd7); c++) @(negedge clk);
    chk("reached_n7", o_en && o_sc_idx == 4'd7, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", o_busy, 0);
    chk("abort_ready", s_ready, 0);
    chk("abort_re_im", {o_re, o_im}, 0);
    chk("abort_angle", o_angle, 0);
    chk("abort_idx", o_sc_idx, 0);
    chk("abort_en_done_err", {o_en, o_done, o_err}, 0);
    sb.delete();
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    load_tab(1); run(2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
